// File: rtl/enflop_pipe.sv
// rtl/enflop_pipe.sv - elastic pipeline of enable flops with valid/ready, flush and occupancy
module enflop_pipe #(
   parameter int              WIDTH    = 9,
   parameter int              DEPTH    = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter bit              RST_DATA = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_vld,
   output logic                       in_rdy,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]            vld;
   logic [DEPTH-1:0]            vld_nxt;
   logic [DEPTH-1:0]            rdy;
   logic [DEPTH-1:0]            load;
   logic [DEPTH-1:0][WIDTH-1:0] data;
   logic [DEPTH-1:0][WIDTH-1:0] d_src;
   logic [OCC_W-1:0]            occ_q;
   logic [OCC_W-1:0]            occ_nxt;

   // A stage is ready if it or any stage after it is empty, or the sink takes data.
   for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
      assign rdy[g] = out_rdy | ~(&vld[DEPTH-1:g]);
   end

   assign in_rdy = rdy[0] & ~flush;

   always_comb begin
      load    = '0;
      d_src   = '0;
      load[0]  = in_vld & in_rdy;
      d_src[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         load[i]  = vld[i-1] & rdy[i] & ~flush;
         d_src[i] = data[i-1];
      end
   end

   always_comb begin
      vld_nxt = '0;
      occ_nxt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         vld_nxt[i] = ~flush & (load[i] | (vld[i] & ~rdy[i]));
         occ_nxt    = occ_nxt + OCC_W'(vld_nxt[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld   <= '0;
         occ_q <= '0;
      end else begin
         vld   <= vld_nxt;
         occ_q <= occ_nxt;
      end
   end

   if (RST_DATA) begin : g_data_rst
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data <= {DEPTH{RST_VAL}};
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (load[i]) data[i] <= d_src[i];
            end
         end
      end
   end else begin : g_data_norst
      always_ff @(posedge clk) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (load[i]) data[i] <= d_src[i];
         end
      end
   end

   assign out_vld   = vld[DEPTH-1];
   assign out_data  = data[DEPTH-1];
   assign occupancy = occ_q;

`ifndef SYNTHESIS
   a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (out_vld && !out_rdy) |=> $stable(out_data));
   a_occ_max : assert property (@(posedge clk) disable iff (!rst_n)
      occupancy <= OCC_W'(DEPTH));
   a_flush_rdy : assert property (@(posedge clk) disable iff (!rst_n)
      flush |-> !in_rdy);
`endif

endmodule

// File: tb/tb_enflop_pipe.sv
// tb/tb_enflop_pipe.sv - self-checking bench for enflop_pipe at DEPTH=2 and DEPTH=3
module tb_enflop_pipe;
   localparam int         W  = 9;
   localparam logic [W-1:0] RV = 9'h0A5;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b0;
   logic         flush   = 1'b0;
   logic         in_vld  = 1'b0;
   logic         out_rdy = 1'b0;
   logic [W-1:0] in_data = '0;
   int           total   = 0;
   int           bad     = 0;

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : u
      localparam int D  = (g == 0) ? 2 : 3;
      localparam int OW = $clog2(D+1);
      logic          in_rdy;
      logic          out_vld;
      logic [W-1:0]  out_data;
      logic [OW-1:0] occupancy;

      enflop_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV), .RST_DATA(1'b1)) dut (
         .clk(clk), .rst_n(rst_n), .flush(flush),
         .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
         .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
         .occupancy(occupancy)
      );

      // Items in FIFO order with the earliest cycle each could reach the output.
      int qd[$];
      int qa[$];
      int last_dep = -1000;
      int cyc = 0;
      bit fresh = 1'b1;
      bit ev, er, xfer, acc;

      function automatic bit head_ready();
         return qd.size() > 0 && cyc >= qa[0] && cyc >= last_dep + 1;
      endfunction

      always @(negedge clk) begin
         ev = head_ready();
         er = !flush && (qd.size() < D || out_rdy);
         check($sformatf("d%0d_cyc%0d_out_vld", D, cyc), int'(out_vld), int'(ev));
         check($sformatf("d%0d_cyc%0d_in_rdy", D, cyc), int'(in_rdy), int'(er));
         check($sformatf("d%0d_cyc%0d_occ", D, cyc), int'(occupancy), qd.size());
         if (ev) begin
            check($sformatf("d%0d_cyc%0d_out_data", D, cyc), int'(out_data), qd[0]);
            fresh = 1'b0;
         end else if (fresh) begin
            check($sformatf("d%0d_cyc%0d_rst_data", D, cyc), int'(out_data), int'(RV));
         end
      end

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            qd.delete();
            qa.delete();
            last_dep = -1000;
            fresh    = 1'b1;
         end else begin
            xfer = head_ready() && out_rdy;
            acc  = in_vld && !flush && (qd.size() < D || out_rdy);
            if (xfer) begin
               void'(qd.pop_front());
               void'(qa.pop_front());
               last_dep = cyc;
            end
            if (flush) begin
               qd.delete();
               qa.delete();
            end
            if (acc) begin
               qd.push_back(int'(in_data));
               qa.push_back(cyc + D);
            end
            cyc++;
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_d2_data", int'(u[0].out_data), 'h0A5);
      check("rst_d2_vld", int'(u[0].out_vld), 0);
      check("rst_d2_occ", int'(u[0].occupancy), 0);
      check("rst_d2_in_rdy", int'(u[0].in_rdy), 1);
      check("rst_d3_data", int'(u[1].out_data), 'h0A5);
      check("rst_d3_occ", int'(u[1].occupancy), 0);
      @(posedge clk);
      #1;
      for (int s = 0; s < 35; s++) begin
         rst_n   = 1'b1;
         in_vld  = 1'b0;
         in_data = '0;
         out_rdy = 1'b1;
         flush   = 1'b0;
         case (s)
            0, 1, 2:     begin in_vld = 1'b1; in_data = W'(s + 1); end
            7, 8, 9, 10: begin in_vld = 1'b1; in_data = W'(s + 4); out_rdy = 1'b0; end
            11:          begin in_vld = 1'b1; in_data = W'(14); out_rdy = 1'b0; end
            12:          begin in_vld = 1'b1; in_data = W'(14); end
            17, 18, 19:  begin in_vld = 1'b1; in_data = W'(s + 4); out_rdy = 1'b0; flush = (s == 19); end
            20:          out_rdy = 1'b0;
            21, 22:      begin in_vld = 1'b1; in_data = W'(s + 20); end
            23:          flush = 1'b1;
            25, 26:      begin in_vld = 1'b1; in_data = W'(s + 6); out_rdy = 1'b0; end
            27:          out_rdy = 1'b0;
            30:          begin in_vld = 1'b1; in_data = W'(5); end
            default:     ;
         endcase
         @(negedge clk);
         case (s)
            2:  begin check("s2_d2_vld", int'(u[0].out_vld), 1); check("s2_d2_data", int'(u[0].out_data), 1); end
            3:  begin check("s3_d2_data", int'(u[0].out_data), 2); check("s3_d3_data", int'(u[1].out_data), 1); end
            4:  begin check("s4_d2_data", int'(u[0].out_data), 3); check("s4_d3_data", int'(u[1].out_data), 2); end
            5:  begin check("s5_d2_vld", int'(u[0].out_vld), 0); check("s5_d3_data", int'(u[1].out_data), 3); end
            6:  check("s6_d3_vld", int'(u[1].out_vld), 0);
            10: begin
               check("s10_d3_occ", int'(u[1].occupancy), 3);
               check("s10_d3_in_rdy", int'(u[1].in_rdy), 0);
               check("s10_d3_data", int'(u[1].out_data), 11);
               check("s10_d2_in_rdy", int'(u[0].in_rdy), 0);
            end
            11: check("s11_d3_hold", int'(u[1].out_data), 11);
            12: begin check("s12_d3_in_rdy", int'(u[1].in_rdy), 1); check("s12_d3_occ", int'(u[1].occupancy), 3); end
            13: begin check("s13_d3_occ", int'(u[1].occupancy), 3); check("s13_d3_data", int'(u[1].out_data), 12); end
            14: begin check("s14_d3_data", int'(u[1].out_data), 13); check("s14_d3_occ", int'(u[1].occupancy), 2); end
            15: begin check("s15_d3_data", int'(u[1].out_data), 14); check("s15_d3_occ", int'(u[1].occupancy), 1); end
            16: check("s16_d3_vld", int'(u[1].out_vld), 0);
            19: begin
               check("s19_d3_occ", int'(u[1].occupancy), 2);
               check("s19_d3_in_rdy", int'(u[1].in_rdy), 0);
               check("s19_d2_in_rdy", int'(u[0].in_rdy), 0);
            end
            20: begin
               check("s20_d3_occ", int'(u[1].occupancy), 0);
               check("s20_d3_vld", int'(u[1].out_vld), 0);
               check("s20_d2_vld", int'(u[0].out_vld), 0);
            end
            23: begin check("s23_d2_vld", int'(u[0].out_vld), 1); check("s23_d2_data", int'(u[0].out_data), 41); end
            24: begin check("s24_d2_vld", int'(u[0].out_vld), 0); check("s24_d2_occ", int'(u[0].occupancy), 0); end
            27: begin check("s27_d2_data", int'(u[0].out_data), 31); check("s27_d3_occ", int'(u[1].occupancy), 2); end
            28: begin check("s28_d2_vld", int'(u[0].out_vld), 0); check("s28_d2_in_rdy", int'(u[0].in_rdy), 1); end
            29: begin check("s29_d3_vld", int'(u[1].out_vld), 0); check("s29_d3_data", int'(u[1].out_data), 'h0A5); end
            32: check("s32_d2_data", int'(u[0].out_data), 5);
            33: check("s33_d3_data", int'(u[1].out_data), 5);
            default: ;
         endcase
         if (s == 27) begin
            #2 rst_n = 1'b0;
            #1;
            check("arst_d2_vld", int'(u[0].out_vld), 0);
            check("arst_d3_occ", int'(u[1].occupancy), 0);
            check("arst_d2_data", int'(u[0].out_data), 'h0A5);
            check("arst_d3_data", int'(u[1].out_data), 'h0A5);
         end
         @(posedge clk);
         #1;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
